// File: rtl/axil_reg_access_arbiter_if.sv
// AXI4-Lite master bundle used by the register access arbiter.
// The master modport drives the request channels, the slave modport answers them.
interface axil_reg_access_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axil_reg_access_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among NUM_REQ
// requesters; one single-word transaction in flight at a time.
module axil_reg_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  axil_reg_access_arbiter_if.master     m_axi
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW_W = 3'd1;
  localparam logic [2:0] WR_B    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [IW-1:0]         rr_q, gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [1:0]            resp_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic                  aw_done_q, w_done_q;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [IW-1:0] sel, idx, rr_nxt;
  logic          sel_found, accept;
  logic          aw_hs, w_hs, ar_hs;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // first valid requester at or after rr_q, wrapping around
  always_comb begin
    sel       = '0;
    idx       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  assign rr_nxt = IW'((int'(sel) + 1) % NUM_REQ);
  assign accept = (state_q == IDLE) && sel_found;

  assign aw_hs = awvalid_q && m_axi.M_AXI_AWREADY;
  assign w_hs  = wvalid_q  && m_axi.M_AXI_WREADY;
  assign ar_hs = arvalid_q && m_axi.M_AXI_ARREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found)
                 state_d = req_we[sel] ? WR_AW_W : RD_AR;
      WR_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                 state_d = WR_B;
      WR_B:    if (m_axi.M_AXI_BVALID) state_d = DONE;
      RD_AR:   if (ar_hs) state_d = RD_R;
      RD_R:    if (m_axi.M_AXI_RVALID) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_q    <= rr_nxt;
        gnt_q   <= sel;
        addr_q  <= addr_arr[sel];
        wdata_q <= wdata_arr[sel];
        if (req_we[sel]) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          arvalid_q <= 1'b1;
        end
      end
      // each channel retires independently; valids never reassert
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (ar_hs) arvalid_q <= 1'b0;
      if (state_q == WR_B && m_axi.M_AXI_BVALID) begin
        rdata_q <= '0;
        resp_q  <= m_axi.M_AXI_BRESP;
      end
      if (state_q == RD_R && m_axi.M_AXI_RVALID) begin
        rdata_q <= m_axi.M_AXI_RDATA;
        resp_q  <= m_axi.M_AXI_RRESP;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept) req_ready[sel] = 1'b1;
    if (state_q == DONE) rsp_valid[gnt_q] = 1'b1;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != IDLE);

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state_q == WR_B);
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = (state_q == RD_R);
endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Directed bench for the AXI4-Lite register access arbiter with a
// small 4-register slave model (programmable AWREADY delay and RRESP).
module tb_axil_reg_access_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;

  axil_reg_access_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  axil_reg_access_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .m_axi(axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_bad;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // slave model
  int          aw_delay, aw_cnt;
  logic [1:0]  rresp_force, rresp_q;
  logic [31:0] sregs [4];
  logic [3:0]  sa_addr, wa;
  logic [31:0] sa_data, wd, s_rdata;
  logic        have_aw, have_w, s_bvalid, s_rvalid;
  logic        s_aw_hs, s_w_hs, s_ar_hs;

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt >= aw_delay);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID;
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
  assign axi.M_AXI_BVALID  = s_bvalid;
  assign axi.M_AXI_BRESP   = 2'b00;
  assign axi.M_AXI_RVALID  = s_rvalid;
  assign axi.M_AXI_RDATA   = s_rdata;
  assign axi.M_AXI_RRESP   = rresp_q;

  assign s_aw_hs = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
  assign s_w_hs  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
  assign s_ar_hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
  assign wa = s_aw_hs ? axi.M_AXI_AWADDR : sa_addr;
  assign wd = s_w_hs ? axi.M_AXI_WDATA : sa_data;

  always @(posedge clk) begin
    if (rst) begin
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      aw_cnt   <= 0;
      sa_addr  <= '0;
      sa_data  <= '0;
      s_rdata  <= '0;
      rresp_q  <= '0;
      for (int i = 0; i < 4; i++) sregs[i] <= '0;
    end else begin
      if (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (s_aw_hs) begin
        sa_addr <= axi.M_AXI_AWADDR;
        have_aw <= 1'b1;
      end
      if (s_w_hs) begin
        sa_data <= axi.M_AXI_WDATA;
        have_w  <= 1'b1;
      end
      if ((have_aw || s_aw_hs) && (have_w || s_w_hs) && !s_bvalid) begin
        sregs[wa[3:2]] <= wd;
        s_bvalid <= 1'b1;
        have_aw  <= 1'b0;
        have_w   <= 1'b0;
      end
      if (s_bvalid && axi.M_AXI_BREADY) s_bvalid <= 1'b0;
      if (s_ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= sregs[axi.M_AXI_ARADDR[3:2]];
        rresp_q  <= rresp_force;
      end
      if (s_rvalid && axi.M_AXI_RREADY) s_rvalid <= 1'b0;
    end
  end

  // bus monitor
  logic        clr;
  int          n_aw, n_w, n_b, n_awv, n_wv, n_rsp0, n_rsp1;
  int          glog [$];
  logic [3:0]  last_awaddr, last_araddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  always @(posedge clk) begin
    if (clr) begin
      n_aw <= 0; n_w <= 0; n_b <= 0; n_awv <= 0; n_wv <= 0;
      n_rsp0 <= 0; n_rsp1 <= 0;
      glog.delete();
    end else begin
      if (axi.M_AXI_AWVALID) n_awv <= n_awv + 1;
      if (axi.M_AXI_WVALID) n_wv <= n_wv + 1;
      if (s_aw_hs) begin
        n_aw <= n_aw + 1;
        last_awaddr <= axi.M_AXI_AWADDR;
      end
      if (s_w_hs) begin
        n_w <= n_w + 1;
        last_wdata <= axi.M_AXI_WDATA;
        last_wstrb <= axi.M_AXI_WSTRB;
      end
      if (s_ar_hs) last_araddr <= axi.M_AXI_ARADDR;
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) n_b <= n_b + 1;
      if (rsp_valid[0]) n_rsp0 <= n_rsp0 + 1;
      if (rsp_valid[1]) n_rsp1 <= n_rsp1 + 1;
      if (req_ready == 2'b01) glog.push_back(0);
      if (req_ready == 2'b10) glog.push_back(1);
    end
  end

  logic [1:0]  cap_v, cap_resp;
  logic [31:0] cap_rdata;

  task automatic clear_mon();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cmd(input int r, input logic we, input logic [3:0] a,
                         input logic [31:0] d, output int lat);
    int t;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*4 +: 4] = a;
    req_wdata[r*32 +: 32] = d;
    #1;
    t = 0;
    while (!req_ready[r] && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 40) chk("ready_timeout", 32'(t), 0);
    @(negedge clk);
    req_valid[r] = 1'b0;
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    cap_v = rsp_valid;
    cap_rdata = rsp_rdata;
    cap_resp = rsp_resp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, c1, t;
    n_chk = 0; n_bad = 0;
    rst = 1'b1; clr = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    aw_delay = 0; rresp_force = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0; clr = 1'b0;

    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_axi_ctl", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID,
        axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_prot", 32'({axi.M_AXI_AWPROT, axi.M_AXI_ARPROT}), 0);
    chk("rst_wstrb", 32'(axi.M_AXI_WSTRB), 32'hF);

    // 1: write, zero-wait slave
    run_cmd(0, 1'b1, 4'h4, 32'h0000_0002, lat);
    chk("t1_lat", 32'(lat), 3);
    chk("t1_rspv", 32'(cap_v), 32'b01);
    chk("t1_resp", 32'(cap_resp), 0);
    chk("t1_rdata", cap_rdata, 0);
    chk("t1_awaddr", 32'(last_awaddr), 32'h4);
    chk("t1_wdata", last_wdata, 32'h2);
    chk("t1_wstrb", 32'(last_wstrb), 32'hF);

    // 2: read back from the other requester
    run_cmd(1, 1'b0, 4'h4, 32'h0, lat);
    chk("t2_lat", 32'(lat), 3);
    chk("t2_rspv", 32'(cap_v), 32'b10);
    chk("t2_rdata", cap_rdata, 32'h0000_0002);
    chk("t2_araddr", 32'(last_araddr), 32'h4);

    // 3: both requesters held valid, 4 commands each
    do_reset();
    clear_mon();
    req_we = 2'b00;
    req_addr = 8'h40;
    req_valid = 2'b11;
    t = 0;
    while (t < 200 && (req_valid != 2'b00 || busy)) begin
      @(negedge clk);
      c0 = 0; c1 = 0;
      foreach (glog[i]) if (glog[i] == 0) c0++; else c1++;
      if (c0 >= 4) req_valid[0] = 1'b0;
      if (c1 >= 4) req_valid[1] = 1'b0;
      t++;
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("t3_ngrant", 32'(glog.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < glog.size()) chk("t3_order", 32'(glog[i]), 32'(i % 2));
    chk("t3_rsp0", 32'(n_rsp0), 4);
    chk("t3_rsp1", 32'(n_rsp1), 4);

    // 4: AWREADY held off 3 cycles, WREADY immediate
    aw_delay = 3;
    clear_mon();
    run_cmd(0, 1'b1, 4'hC, 32'hA5A5_0001, lat);
    aw_delay = 0;
    chk("t4_lat", 32'(lat), 6);
    chk("t4_awv_cyc", 32'(n_awv), 4);
    chk("t4_wv_cyc", 32'(n_wv), 1);
    chk("t4_aw_hs", 32'(n_aw), 1);
    chk("t4_w_hs", 32'(n_w), 1);
    chk("t4_b_hs", 32'(n_b), 1);
    chk("t4_rspv", 32'(cap_v), 32'b01);

    // 5: reset while waiting for read data
    clear_mon();
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_addr[7:4] = 4'h0;
    #1;
    t = 0;
    while (!req_ready[1] && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("t5_arvalid", 32'(axi.M_AXI_ARVALID), 1);
    @(negedge clk);
    chk("t5_rready", 32'(axi.M_AXI_RREADY), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_outs", 32'({req_ready, rsp_valid, rsp_resp}), 0);
    chk("t5_rdata", rsp_rdata, 0);
    chk("t5_axi_ctl", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID,
        axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}), 0);
    repeat (3) @(negedge clk);
    chk("t5_no_rsp", 32'(n_rsp0 + n_rsp1), 0);
    run_cmd(0, 1'b1, 4'h8, 32'h1234_5678, lat);
    chk("t5_after_lat", 32'(lat), 3);
    chk("t5_after_rspv", 32'(cap_v), 32'b01);

    // 6: SLVERR passed through on a read
    rresp_force = 2'b10;
    clear_mon();
    run_cmd(1, 1'b0, 4'h8, 32'h0, lat);
    rresp_force = 2'b00;
    chk("t6_resp", 32'(cap_resp), 32'h2);
    chk("t6_rdata", cap_rdata, 32'h1234_5678);
    chk("t6_rspv", 32'(cap_v), 32'b10);
    repeat (3) @(negedge clk);
    chk("t6_rsp1_cnt", 32'(n_rsp1), 1);
    chk("t6_rsp0_cnt", 32'(n_rsp0), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
